// File: rtl/shift_reg_arbiter_ctrl_if.sv
// Handshake and serial-output bundle for shift_reg_arbiter_ctrl.
// master = requester/consumer side, slave = the controller.
interface shift_reg_arbiter_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             ser_owner;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  ser_out, ser_valid, ser_first, ser_last, ser_owner, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output ser_out, ser_valid, ser_first, ser_last, ser_owner, busy
  );
endinterface

// File: rtl/shift_reg_arbiter_ctrl.sv
// Two-requester round-robin front end that serialises one granted word per frame.
// Define SHIFT_CTRL_MSB_FIRST_EN to shift MSB first; default build is LSB first.

// Per-requester grant: wins if alone, or if it was not the one served last.
module shift_reg_arbiter_ctrl_lane #(
  parameter int IDX = 0
) (
  input  logic [1:0] valid,
  input  logic       last_served,
  input  logic       idle,
  output logic       ready
);
  localparam logic ME    = (IDX != 0);
  localparam logic OTHER = ~ME;

  assign ready = idle & valid[ME] & (~valid[OTHER] | (last_served != ME));
endmodule

module shift_reg_arbiter_ctrl #(
  parameter int WIDTH = 32,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  shift_reg_arbiter_ctrl_if.slave  bus
);
  localparam int NUM_REQ = 2;
  localparam int MAXC    = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW      = $clog2(MAXC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

  state_e                            state_q, state_d;
  logic [WIDTH-1:0]                  shreg_q, shreg_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic                              owner_q, owner_d;
  logic                              last_served_q, last_served_d;

  logic ser_out_q, ser_out_d;
  logic ser_valid_q, ser_valid_d;
  logic ser_first_q, ser_first_d;
  logic ser_last_q, ser_last_d;
  logic ser_owner_q, ser_owner_d;
  logic busy_q, busy_d;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_data  = {bus.req1_data, bus.req0_data};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    shift_reg_arbiter_ctrl_lane #(.IDX(g)) u_lane (
      .valid       (req_valid),
      .last_served (last_served_q),
      .idle        (state_q == S_IDLE),
      .ready       (req_ready[g])
    );
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      ser_first_q   <= 1'b0;
      ser_last_q    <= 1'b0;
      ser_owner_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      ser_first_q   <= ser_first_d;
      ser_last_q    <= ser_last_d;
      ser_owner_q   <= ser_owner_d;
      busy_q        <= busy_d;
    end
  end

  // Next state and datapath; cnt restarts at 0 on entry to SHIFT and GAP.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    case (state_q)
      S_IDLE: begin
        if (|req_ready) begin
          state_d       = S_SHIFT;
          shreg_d       = req_ready[1] ? req_data[1] : req_data[0];
          owner_d       = req_ready[1];
          last_served_d = req_ready[1];
          cnt_d         = '0;
        end
      end
      S_SHIFT: begin
`ifdef SHIFT_CTRL_MSB_FIRST_EN
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`else
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
`endif
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next state so the serial pins come straight off flops.
  always_comb begin
    ser_valid_d = (state_d == S_SHIFT);
`ifdef SHIFT_CTRL_MSB_FIRST_EN
    ser_out_d   = ser_valid_d & shreg_d[WIDTH-1];
`else
    ser_out_d   = ser_valid_d & shreg_d[0];
`endif
    ser_first_d = ser_valid_d & (cnt_d == '0);
    ser_last_d  = ser_valid_d & (cnt_d == CNT_LAST);
    ser_owner_d = ser_valid_d & owner_d;
    busy_d      = (state_d != S_IDLE);
  end

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_first = ser_first_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.ser_owner = ser_owner_q;
  assign bus.busy      = busy_q;
endmodule
